apb_master_arbiter: RTL and testbench
=====================================

// Module: apb_master_arbiter
// PURPOSE
// - Shares one APB master port between N requesters (CPU load/store unit, debug, DMA) in front of APB peripherals (gpio, timers).
// - Round-robin arbitration; one APB transfer in flight at a time; sequences SETUP/ACCESS phases and returns read data per requester.
// PARAMETERS
// - N_REQ          2   number of requesters (2..8)
// - ADDR_WIDTH     32  APB address width
// - DATA_WIDTH     32  APB data width
// - TIMEOUT_CYCLES 16  max ACCESS cycles before abort (used only with APB_ARB_TIMEOUT_EN)
// PORTS
// - clk        in   1                      single clock, also drives the APB PCLK
// - arst       in   1                      asynchronous, active-high reset
// - req_valid  in   N_REQ                  request pending; held with its fields until matching rsp_valid
// - req_write  in   N_REQ                  1 = write, 0 = read, per requester
// - req_addr   in   N_REQ*ADDR_WIDTH       packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
// - req_wdata  in   N_REQ*DATA_WIDTH       packed write data, same packing
// - rsp_valid  out  N_REQ                  one-cycle completion pulse to the granted requester
// - rsp_rdata  out  DATA_WIDTH             read data, valid while any rsp_valid is high
// - rsp_err    out  1                      timeout abort flag, valid with rsp_valid
// - psel, penable, pwrite  out  1          APB master controls
// - paddr      out  ADDR_WIDTH             APB address
// - pwdata     out  DATA_WIDTH             APB write data
// - pready     in   1                      APB slave ready
// - prdata     in   DATA_WIDTH             APB read data
// BEHAVIOUR
// - Reset (async, immediate): state IDLE; all outputs 0; RR pointer last_grant = N_REQ-1, so requester 0 has top priority.
// - FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
// - IDLE: if any req_valid, grant the first valid index starting at last_grant+1 mod N_REQ. Latch idx/addr/wdata/write into regs; update last_grant; go to SETUP.
// - SETUP (1 cycle): psel=1, penable=0, paddr/pwrite/pwdata from latched regs; go to ACCESS.
// - ACCESS: psel=1, penable=1, fields unchanged. Stay while pready=0. When pready=1: capture prdata (write: rsp_rdata=0) and go to RESP.
// - RESP (1 cycle): psel=penable=0; rsp_valid[idx]=1 with rsp_rdata/rsp_err; req_valid ignored this cycle. Requester drops or changes its request here.
// - Minimum 4 cycles per transfer. Peripherals with a registered PREADY add >=1 ACCESS cycle.
// - req_valid dropped mid-transfer: transfer still completes on APB; rsp_valid still pulses.
// - Only the granted requester's latched fields are used; other inputs may change freely.
// - paddr/pwdata/pwrite hold last values in IDLE/RESP; they are don't-care while psel=0.
// - Reset mid-transfer: APB aborted (psel/penable low asynchronously); no rsp_valid is issued.
// CONFIGURATION
// - APB_ARB_TIMEOUT_EN defined:
//   - 8-bit ACCESS cycle counter, cleared in SETUP.
//   - If TIMEOUT_CYCLES ACCESS cycles pass with pready=0: drop psel/penable, go to RESP with rsp_err=1, rsp_rdata=0.
//   - A pready arriving in the final counted cycle wins (normal completion).
// - APB_ARB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; rsp_err tied 0.
// STRUCTURE
// - Package apb_arb_pkg: state_t enum {IDLE, SETUP, ACCESS, RESP}; localparam IDX_W = $clog2(N_REQ) (min 1).
// - Sub-module rr_arbiter: combinational grant from req vector and last_grant; outputs one-hot grant and index.
// - FSM, latches and optional timeout stay in apb_master_arbiter.
// TESTING
// - Single read: req0 addr 0x8, slave pready one cycle after penable, prdata 0xA5A5_0001 -> psel at cycle 1, penable cycles 2-3, rsp_valid[0] cycle 4, rsp_rdata 0xA5A5_0001.
// - Write to gpio-style slave: req1 write addr 0x0 data 0xFF -> pwrite=1, pwdata=0xFF stable through SETUP+ACCESS; rsp_valid[1], rsp_err=0.
// - Fairness: req0 and req1 both held continuously -> grants alternate 0,1,0,1 over 4 transfers; first grant 0 after reset.
// - Wait states: pready low for 5 ACCESS cycles -> psel/penable/paddr unchanged throughout; single rsp_valid after pready.
// - Timeout (macro on, TIMEOUT_CYCLES=4): pready never asserted -> after 4 ACCESS cycles psel=0, rsp_err=1, rsp_rdata=0; next request proceeds normally.
// - Reset mid-ACCESS: arst pulse -> psel/penable 0 without clock edge; no rsp_valid; post-reset grant goes to requester 0.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB master arbiter: FSM state encoding and
// grant-index width calculation.
package apb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   // Requester index width, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int N_REQ_DEF = 2;
   localparam int IDX_W     = idx_width(N_REQ_DEF);

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1 (mod N_REQ)
// and returns the first pending requester as a one-hot vector and an index.
module rr_arbiter
   import apb_arb_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int IW    = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    last_grant,
   output logic [N_REQ-1:0] grant,
   output logic [IW-1:0]    grant_idx
);

   logic [IW-1:0] cand_s;
   logic          hit_s;
   logic          found_s;

   // Rotating priority search; the first hit masks all later candidates.
   always_comb begin
      grant     = {N_REQ{1'b0}};
      grant_idx = {IW{1'b0}};
      found_s   = 1'b0;
      cand_s    = {IW{1'b0}};
      hit_s     = 1'b0;
      for (int off = 1; off <= N_REQ; off++) begin
         cand_s    = IW'((int'(last_grant) + off) % N_REQ);
         hit_s     = req[cand_s] & ~found_s;
         grant     = grant | ({{(N_REQ-1){1'b0}}, hit_s} << cand_s);
         grant_idx = hit_s ? cand_s : grant_idx;
         found_s   = found_s | hit_s;
      end
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin sharing of one APB master port between N_REQ requesters.
// Optional ACCESS-phase timeout abort is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int N_REQ          = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                        clk,
   input  logic                        arst,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ-1:0]            req_write,
   input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [N_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]       rsp_rdata,
   output logic                        rsp_err,
   output logic                        psel,
   output logic                        penable,
   output logic                        pwrite,
   output logic [ADDR_WIDTH-1:0]       paddr,
   output logic [DATA_WIDTH-1:0]       pwdata,
   input  logic                        pready,
   input  logic [DATA_WIDTH-1:0]       prdata
);

   localparam int IW = idx_width(N_REQ);

   state_t                  state_r;
   state_t                  next_state_s;
   logic [IW-1:0]           last_grant_r;
   logic [N_REQ-1:0]        gnt_r;
   logic [N_REQ-1:0]        grant_s;
   logic [IW-1:0]           grant_idx_s;
   logic                    any_req_s;
   logic                    take_s;
   logic                    done_s;
   logic                    timeout_s;
   logic                    timeout_hit_s;
   logic                    write_r;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [DATA_WIDTH-1:0]   wdata_r;
   logic                    psel_r;
   logic                    penable_r;
   logic [N_REQ-1:0]        rsp_valid_r;
   logic [DATA_WIDTH-1:0]   rsp_rdata_r;
   logic                    rsp_err_r;

   assign any_req_s = |req_valid;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_rr (
      .req        (req_valid),
      .last_grant (last_grant_r),
      .grant      (grant_s),
      .grant_idx  (grant_idx_s)
   );

`ifdef APB_ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] acc_cnt_r;

   // Counts ACCESS cycles of the current transfer; restarted in SETUP.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         acc_cnt_r <= 8'd0;
      end else if (state_r == SETUP) begin
         acc_cnt_r <= 8'd0;
      end else if (state_r == ACCESS) begin
         acc_cnt_r <= acc_cnt_r + 8'd1;
      end else begin
         acc_cnt_r <= acc_cnt_r;
      end
   end

   assign timeout_hit_s = (acc_cnt_r == TO_LAST);
`else
   assign timeout_hit_s = 1'b0;
`endif

   // Next-state decode; pready in the last counted cycle beats the timeout.
   always_comb begin
      next_state_s = state_r;
      take_s       = 1'b0;
      done_s       = 1'b0;
      timeout_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (any_req_s) begin
               next_state_s = SETUP;
               take_s       = 1'b1;
            end else begin
               next_state_s = IDLE;
            end
         end
         SETUP: next_state_s = ACCESS;
         ACCESS: begin
            if (pready) begin
               next_state_s = RESP;
               done_s       = 1'b1;
            end else if (timeout_hit_s) begin
               next_state_s = RESP;
               done_s       = 1'b1;
               timeout_s    = 1'b1;
            end else begin
               next_state_s = ACCESS;
            end
         end
         RESP:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // State, latched transfer fields and registered APB/response outputs.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_r      <= IDLE;
         last_grant_r <= IW'(N_REQ - 1);
         gnt_r        <= {N_REQ{1'b0}};
         write_r      <= 1'b0;
         addr_r       <= {ADDR_WIDTH{1'b0}};
         wdata_r      <= {DATA_WIDTH{1'b0}};
         psel_r       <= 1'b0;
         penable_r    <= 1'b0;
         rsp_valid_r  <= {N_REQ{1'b0}};
         rsp_rdata_r  <= {DATA_WIDTH{1'b0}};
         rsp_err_r    <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         psel_r    <= (next_state_s == SETUP) || (next_state_s == ACCESS);
         penable_r <= (next_state_s == ACCESS);
         if (take_s) begin
            gnt_r        <= grant_s;
            last_grant_r <= grant_idx_s;
            write_r      <= req_write[grant_idx_s];
            addr_r       <= req_addr[grant_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_r      <= req_wdata[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
         end
         if (done_s) begin
            rsp_valid_r <= gnt_r;
            rsp_rdata_r <= (pready && !write_r) ? prdata : {DATA_WIDTH{1'b0}};
            rsp_err_r   <= timeout_s;
         end else begin
            rsp_valid_r <= {N_REQ{1'b0}};
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
         end
      end
   end

   assign psel      = psel_r;
   assign penable   = penable_r;
   assign pwrite    = write_r;
   assign paddr     = addr_r;
   assign pwdata    = wdata_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed self-checking bench for apb_master_arbiter (two requesters).
// The timeout scenario runs only when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_master_arbiter;

   logic        clk = 1'b0;
   logic        arst;
   logic [1:0]  req_valid, req_write;
   logic [63:0] req_addr, req_wdata;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err, psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic        pready;
   logic [31:0] prdata;

   int n_pass  = 0;
   int n_total = 0;

   apb_master_arbiter #(
      .N_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
   ) dut (
      .clk(clk), .arst(arst),
      .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata),
      .pready(pready), .prdata(prdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for SETUP, serves ACCESS with 'waits' stall cycles, checks RESP.
   task automatic serve(input string tag, input int exp_idx, input logic [31:0] exp_addr,
                        input logic exp_wr, input logic [31:0] exp_wd, input int waits,
                        input logic [31:0] rd, input logic [31:0] exp_rd, output int lat);
      int n = 0;
      while (!(psel === 1'b1 && penable === 1'b0) && n < 20) begin
         tick();
         n++;
      end
      lat = n;
      chk({tag, ":setup"}, {psel, penable, pwrite}, {1'b1, 1'b0, exp_wr});
      chk({tag, ":paddr"}, paddr, exp_addr);
      if (exp_wr) chk({tag, ":pwdata"}, pwdata, exp_wd);
      for (int i = 0; i <= waits; i++) begin
         tick();
         chk({tag, ":access"}, {psel, penable, pwrite}, {1'b1, 1'b1, exp_wr});
         chk({tag, ":acc_addr"}, paddr, exp_addr);
         if (exp_wr) chk({tag, ":acc_wdata"}, pwdata, exp_wd);
         if (i == waits) begin
            pready = 1'b1;
            prdata = rd;
         end
      end
      tick();
      pready = 1'b0;
      prdata = 32'h0;
      chk({tag, ":rsp_valid"}, rsp_valid, 2'b01 << exp_idx);
      chk({tag, ":rsp_rdata"}, rsp_rdata, exp_rd);
      chk({tag, ":rsp_err"}, rsp_err, 1'b0);
      chk({tag, ":psel_resp"}, {psel, penable}, 2'b00);
   endtask

   initial begin
      int lat;
      int n;
      arst = 1'b1; req_valid = 2'b00; req_write = 2'b00;
      req_addr = 64'h0; req_wdata = 64'h0; pready = 1'b0; prdata = 32'h0;
      tick();
      tick();
      chk("rst_apb", {psel, penable, pwrite}, 3'b000);
      chk("rst_rsp", {rsp_valid, rsp_err}, 3'b000);
      chk("rst_data", {paddr, rsp_rdata}, 64'h0);
      arst = 1'b0;
      tick();

      // Single read from requester 0
      req_valid = 2'b01; req_addr[31:0] = 32'h8;
      serve("read", 0, 32'h8, 1'b0, 32'h0, 1, 32'hA5A5_0001, 32'hA5A5_0001, lat);
      chk("read_lat", lat, 1);
      req_valid = 2'b00;
      tick();
      chk("read_single_pulse", rsp_valid, 2'b00);

      // Write from requester 1; read data must not leak into rsp_rdata
      req_valid = 2'b10; req_write = 2'b10; req_addr[63:32] = 32'h0; req_wdata[63:32] = 32'hFF;
      serve("write", 1, 32'h0, 1'b1, 32'hFF, 0, 32'hDEAD_BEEF, 32'h0, lat);
      req_valid = 2'b00; req_write = 2'b00;
      tick();

      // Fairness after reset: both held, grants alternate starting at 0
      arst = 1'b1;
      tick();
      arst = 1'b0;
      req_valid = 2'b11; req_addr = {32'h20, 32'h10};
      serve("fair0", 0, 32'h10, 1'b0, 32'h0, 0, 32'h100, 32'h100, lat);
      serve("fair1", 1, 32'h20, 1'b0, 32'h0, 0, 32'h101, 32'h101, lat);
      serve("fair2", 0, 32'h10, 1'b0, 32'h0, 0, 32'h102, 32'h102, lat);
      serve("fair3", 1, 32'h20, 1'b0, 32'h0, 0, 32'h103, 32'h103, lat);
      req_valid = 2'b00;
      tick();

      // Five wait states with fields held stable
      req_valid = 2'b01; req_addr[31:0] = 32'h30;
      serve("wait", 0, 32'h30, 1'b0, 32'h0, 5, 32'h1234, 32'h1234, lat);
      req_valid = 2'b00;
      tick();
      chk("wait_single_pulse", rsp_valid, 2'b00);

      // Reset during ACCESS: asynchronous abort, no response, priority back to 0
      req_valid = 2'b10; req_addr[63:32] = 32'h50;
      n = 0;
      while (penable !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("mid_in_access", {psel, penable}, 2'b11);
      arst = 1'b1;
      #1;
      chk("mid_async_abort", {psel, penable}, 2'b00);
      chk("mid_no_rsp", rsp_valid, 2'b00);
      req_valid = 2'b11; req_addr = {32'h50, 32'h60};
      tick();
      chk("mid_no_rsp_held", rsp_valid, 2'b00);
      arst = 1'b0;
      serve("post_rst", 0, 32'h60, 1'b0, 32'h0, 0, 32'h77, 32'h77, lat);
      req_valid = 2'b00;
      tick();

`ifdef APB_ARB_TIMEOUT_EN
      // Timeout: pready never arrives for requester 1
      req_valid = 2'b10; req_addr[63:32] = 32'h40;
      n = 0;
      while (!(psel === 1'b1 && penable === 1'b0) && n < 20) begin
         tick();
         n++;
      end
      chk("to_setup", {psel, penable}, 2'b10);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("to_access", {psel, penable}, 2'b11);
      end
      prdata = 32'hFFFF_FFFF;
      tick();
      chk("to_psel", {psel, penable}, 2'b00);
      chk("to_rsp", {rsp_valid, rsp_err}, {2'b10, 1'b1});
      chk("to_rdata", rsp_rdata, 32'h0);
      req_valid = 2'b00; prdata = 32'h0;
      tick();
      req_valid = 2'b01; req_addr[31:0] = 32'h44;
      serve("to_next", 0, 32'h44, 1'b0, 32'h0, 1, 32'h55, 32'h55, lat);
      req_valid = 2'b00;
      tick();
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
